// File: rtl/rtc_time_counter.sv
// Time-of-day counter in packed BCD (24-hour), advanced by a one-cycle tick.
// Supports validated time-set, snapshot capture and a day-rollover pulse.
module rtc_time_counter #(
  parameter logic [7:0] INIT_HOURS = 8'h00,
  parameter logic [7:0] INIT_MINS  = 8'h00,
  parameter logic [7:0] INIT_SECS  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_valid,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_mins,
  input  logic [7:0] set_secs,
  output logic       set_ack,
  output logic       set_err,
  input  logic       snap_req,
  output logic       snap_valid,
  output logic [7:0] snap_hours,
  output logic [7:0] snap_mins,
  output logic [7:0] snap_secs,
  output logic [7:0] hours,
  output logic [7:0] mins,
  output logic [7:0] secs,
  output logic       day_pulse
);

  logic [7:0] hours_q, hours_d, mins_q, mins_d, secs_q, secs_d;
  logic [7:0] snap_hours_q, snap_hours_d, snap_mins_q, snap_mins_d;
  logic [7:0] snap_secs_q, snap_secs_d;
  logic       set_ack_q, set_ack_d, set_err_q, set_err_d;
  logic       snap_valid_q, snap_valid_d, day_pulse_q, day_pulse_d;
  logic       set_ok;
  logic [8:0] secs_inc, mins_inc, hours_inc;

  // Returns {carry, next}: wraps to 00 with carry at the field maximum,
  // otherwise a plain two-digit BCD increment.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                         input logic [3:0] tens_max,
                                         input logic [3:0] units_max);
    logic [8:0] r;
    if (v[7:4] == tens_max && v[3:0] == units_max)
      r = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    set_ok = (set_secs[3:0] <= 4'd9) && (set_secs[7:4] <= 4'd5) &&
             (set_mins[3:0] <= 4'd9) && (set_mins[7:4] <= 4'd5) &&
             (set_hours[3:0] <= 4'd9) && (set_hours[7:4] <= 4'd2) &&
             !(set_hours[7:4] == 4'd2 && set_hours[3:0] > 4'd3);
  end

  always_comb begin
    secs_inc  = bcd_inc(secs_q, 4'd5, 4'd9);
    mins_inc  = bcd_inc(mins_q, 4'd5, 4'd9);
    hours_inc = bcd_inc(hours_q, 4'd2, 4'd3);
  end

  always_comb begin
    hours_d      = hours_q;
    mins_d       = mins_q;
    secs_d       = secs_q;
    snap_hours_d = snap_hours_q;
    snap_mins_d  = snap_mins_q;
    snap_secs_d  = snap_secs_q;
    set_ack_d    = 1'b0;
    set_err_d    = 1'b0;
    snap_valid_d = 1'b0;
    day_pulse_d  = 1'b0;

    // An accepted set wins over a coincident tick; a rejected one lets it through.
    if (set_valid && set_ok) begin
      hours_d   = set_hours;
      mins_d    = set_mins;
      secs_d    = set_secs;
      set_ack_d = 1'b1;
    end else begin
      set_err_d = set_valid;
      if (tick) begin
        secs_d = secs_inc[7:0];
        if (secs_inc[8]) begin
          mins_d = mins_inc[7:0];
          if (mins_inc[8]) begin
            hours_d     = hours_inc[7:0];
            day_pulse_d = hours_inc[8];
          end
        end
      end
    end

    if (snap_req) begin
      snap_hours_d = hours_q;
      snap_mins_d  = mins_q;
      snap_secs_d  = secs_q;
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hours_q      <= INIT_HOURS;
      mins_q       <= INIT_MINS;
      secs_q       <= INIT_SECS;
      snap_hours_q <= '0;
      snap_mins_q  <= '0;
      snap_secs_q  <= '0;
      set_ack_q    <= 1'b0;
      set_err_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      day_pulse_q  <= 1'b0;
    end else begin
      hours_q      <= hours_d;
      mins_q       <= mins_d;
      secs_q       <= secs_d;
      snap_hours_q <= snap_hours_d;
      snap_mins_q  <= snap_mins_d;
      snap_secs_q  <= snap_secs_d;
      set_ack_q    <= set_ack_d;
      set_err_q    <= set_err_d;
      snap_valid_q <= snap_valid_d;
      day_pulse_q  <= day_pulse_d;
    end
  end

  assign hours      = hours_q;
  assign mins       = mins_q;
  assign secs       = secs_q;
  assign snap_hours = snap_hours_q;
  assign snap_mins  = snap_mins_q;
  assign snap_secs  = snap_secs_q;
  assign set_ack    = set_ack_q;
  assign set_err    = set_err_q;
  assign snap_valid = snap_valid_q;
  assign day_pulse  = day_pulse_q;

endmodule
